// File: rtl/fft_peak_detect.sv
// Purpose: scans bins 1..N/2-1 of a finished FFT frame and reports the largest-magnitude bin (optional threshold gate via PEAK_THRESHOLD_EN).
// Latency: Start accepted at edge 0 -> Done high after edge N/2+1 (one address-preload cycle, N/2-1 reads, one drain cycle).
// Backpressure: none on the read side (memory answers one cycle after rd_en); results held in DONE until Ack, Start ignored outside IDLE.
module fft_peak_detect #(
    parameter int N = 1024,
    parameter int M = 10
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Ack,
    output logic [M-1:0]        rd_addr,
    output logic                rd_en,
    input  logic signed [31:0]  bin_re,
    input  logic signed [31:0]  bin_im,
    output logic [M-1:0]        peak_bin,
    output logic [63:0]         peak_mag,
    output logic                Busy,
`ifdef PEAK_THRESHOLD_EN
    input  logic [63:0]         threshold,
    output logic                peak_valid,
`endif
    output logic                Done
);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_SCAN  = 4'b0010;
    localparam logic [3:0] S_DRAIN = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    // Highest positive-frequency bin; DC and the mirrored half are never read.
    localparam logic [M-1:0] LAST_ADDR = M'(N / 2 - 1);

    logic [3:0]         state;

    // Tracks which address the memory is answering this cycle.
    logic               smp_vld;
    logic [M-1:0]       smp_bin;

    logic [63:0]        run_max;
    logic [M-1:0]       run_bin;

    logic signed [63:0] re_x;
    logic signed [63:0] im_x;
    logic signed [63:0] sq_re;
    logic signed [63:0] sq_im;
    logic [63:0]        mag;
    logic               take;
    logic [63:0]        fin_max;
    logic [M-1:0]       fin_bin;

`ifdef PEAK_THRESHOLD_EN
    logic [63:0]        thr_q;
`endif

    // Magnitude of the returned sample and the running-max candidate (strictly greater wins, so ties keep the lower bin).
    always_comb begin
        re_x    = {{32{bin_re[31]}}, bin_re};
        im_x    = {{32{bin_im[31]}}, bin_im};
        sq_re   = re_x * re_x;
        sq_im   = im_x * im_x;
        mag     = $unsigned(sq_re) + $unsigned(sq_im);
        take    = smp_vld && (mag > run_max);
        fin_max = take ? mag : run_max;
        fin_bin = take ? smp_bin : run_bin;
    end

    // Status decode from the one-hot state.
    always_comb begin
        Busy = (state == S_SCAN) || (state == S_DRAIN);
        Done = (state == S_DONE);
    end

    // Control FSM, read address generation, running max and result registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            smp_vld  <= 1'b0;
            smp_bin  <= '0;
            run_max  <= '0;
            run_bin  <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
`ifdef PEAK_THRESHOLD_EN
            thr_q      <= '0;
            peak_valid <= 1'b0;
`endif
        end else begin
            smp_vld <= rd_en;
            smp_bin <= rd_addr;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state   <= S_SCAN;
                        run_max <= '0;
                        run_bin <= '0;
                        rd_addr <= '0;
`ifdef PEAK_THRESHOLD_EN
                        thr_q   <= threshold;
`endif
                    end
                end
                S_SCAN: begin
                    run_max <= fin_max;
                    run_bin <= fin_bin;
                    // First SCAN cycle preloads address 1; the last address hands over to DRAIN.
                    if (rd_en && (rd_addr == LAST_ADDR)) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The last sample arrives this cycle; fold it in and publish.
                    run_max <= fin_max;
                    run_bin <= fin_bin;
                    state   <= S_DONE;
`ifdef PEAK_THRESHOLD_EN
                    if (fin_max >= thr_q) begin
                        peak_valid <= 1'b1;
                        peak_bin   <= fin_bin;
                        peak_mag   <= fin_max;
                    end else begin
                        peak_valid <= 1'b0;
                        peak_bin   <= '0;
                        peak_mag   <= '0;
                    end
`else
                    peak_bin <= fin_bin;
                    peak_mag <= fin_max;
`endif
                end
                S_DONE: begin
                    if (Ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Purpose: randomized and directed frames checked by a scoreboard against a bin-by-bin reference model.
// Latency: each frame expects Done N/2+1 edges after the Start edge.
// Backpressure: memory model answers one cycle after rd_en; Ack issued by the bench after results are checked.
module tb_fft_peak_detect;

    localparam int N    = 1024;
    localparam int M    = 10;
    localparam int HALF = N / 2;

    logic                Clk;
    logic                Reset;
    logic                Start;
    logic                Ack;
    logic [M-1:0]        rd_addr;
    logic                rd_en;
    logic signed [31:0]  bin_re;
    logic signed [31:0]  bin_im;
    logic [M-1:0]        peak_bin;
    logic [63:0]         peak_mag;
    logic                Busy;
    logic                Done;
`ifdef PEAK_THRESHOLD_EN
    logic [63:0]         threshold;
    logic                peak_valid;
    logic [63:0]         cur_thr;
`endif

    typedef struct packed {
        logic [M-1:0] bin;
        logic [63:0]  mag;
        logic         vld;
    } exp_t;

    exp_t   sb_q[$];
    int     read_log[$];
    int     mem_re[N];
    int     mem_im[N];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc        = 0;
    longint start_edge = 0;

    fft_peak_detect #(.N(N), .M(M)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Ack        (Ack),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .bin_re     (bin_re),
        .bin_im     (bin_im),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .Busy       (Busy),
`ifdef PEAK_THRESHOLD_EN
        .threshold  (threshold),
        .peak_valid (peak_valid),
`endif
        .Done       (Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous FFT result memory: data one cycle after the read strobe.
    always @(posedge Clk) begin
        if (rd_en) begin
            bin_re <= mem_re[rd_addr];
            bin_im <= mem_im[rd_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sq(input int v);
        longint p;
        p = longint'(v) * longint'(v);
        return p;
    endfunction

    // Reference: largest re^2+im^2 over bins 1..N/2-1, first occurrence wins.
    function automatic exp_t model();
        exp_t        e;
        logic [63:0] m;
        e.bin = '0;
        e.mag = '0;
        e.vld = 1'b1;
        for (int b = 1; b < HALF; b++) begin
            m = sq(mem_re[b]) + sq(mem_im[b]);
            if (m > e.mag) begin
                e.mag = m;
                e.bin = M'(b);
            end
        end
`ifdef PEAK_THRESHOLD_EN
        if (e.mag < cur_thr) begin
            e.vld = 1'b0;
            e.bin = '0;
            e.mag = '0;
        end
`endif
        return e;
    endfunction

    // Monitor: logs reads and checks each completed scan against the scoreboard.
    initial begin : monitor
        exp_t e;
        bit   ok;
        bit   done_prev;
        int   bad;
        done_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (rd_en === 1'b1) read_log.push_back(int'(rd_addr));
            if (Done === 1'b1 && !done_prev) begin
                check("done_has_request", 64'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("done_latency", 64'(cyc - start_edge), HALF + 1);
                    check("peak_bin", 64'(peak_bin), 64'(e.bin));
                    check("peak_mag", peak_mag, e.mag);
                    check("busy_in_done", 64'(Busy), 0);
                    check("rd_en_in_done", 64'(rd_en), 0);
`ifdef PEAK_THRESHOLD_EN
                    check("peak_valid", 64'(peak_valid), 64'(e.vld));
`endif
                    ok  = (read_log.size() == HALF - 1);
                    bad = 0;
                    foreach (read_log[i]) begin
                        if (read_log[i] != i + 1) ok = 1'b0;
                        if (read_log[i] == 0 || read_log[i] >= HALF) bad++;
                    end
                    check("read_sequence", 64'(ok), 1);
                    check("dc_or_upper_reads", 64'(bad), 0);
                end
            end
            done_prev = (Done === 1'b1);
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            mem_re[i] = 0;
            mem_im[i] = 0;
        end
    endtask

    task automatic do_start();
        @(negedge Clk);
        read_log.delete();
`ifdef PEAK_THRESHOLD_EN
        threshold = cur_thr;
`endif
        Start = 1'b1;
        @(posedge Clk);
        #1;
        start_edge = cyc;
        Start = 1'b0;
        check("busy_after_start", 64'(Busy), 1);
    endtask

    task automatic run_frame();
        exp_t e;
        bit   got;
        e = model();
        sb_q.push_back(e);
        do_start();
`ifdef PEAK_THRESHOLD_EN
        threshold = ~cur_thr;
`endif
        repeat (5) @(negedge Clk);
        Ack = 1'b1;
        @(posedge Clk);
        #1;
        Ack = 1'b0;
        check("ack_in_scan_ignored", 64'(Busy), 1);
        got = 1'b0;
        for (int i = 0; i < 2 * N && !got; i++) begin
            @(negedge Clk);
            #1;
            if (Done === 1'b1) got = 1'b1;
        end
        check("done_within_budget", 64'(got), 1);
        if (!got) begin
            sb_q.delete();
            return;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 0);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check("start_in_done_done", 64'(Done), 1);
        check("start_in_done_busy", 64'(Busy), 0);
        @(negedge Clk);
        Ack = 1'b1;
        @(posedge Clk);
        #1;
        Ack = 1'b0;
        check("ack_done_low", 64'(Done), 0);
        check("held_peak_bin", 64'(peak_bin), 64'(e.bin));
        check("held_peak_mag", peak_mag, e.mag);
        @(posedge Clk);
        #1;
        check("idle_not_busy", 64'(Busy), 0);
    endtask

    initial begin : stimulus
        Reset = 1'b1;
        Start = 1'b0;
        Ack   = 1'b0;
`ifdef PEAK_THRESHOLD_EN
        cur_thr   = '0;
        threshold = '0;
`endif
        clear_mem();
        repeat (3) @(posedge Clk);
        #1;
        check("rst_rd_en", 64'(rd_en), 0);
        check("rst_rd_addr", 64'(rd_addr), 0);
        check("rst_busy", 64'(Busy), 0);
        check("rst_done", 64'(Done), 0);
        check("rst_peak_bin", 64'(peak_bin), 0);
        check("rst_peak_mag", peak_mag, 0);
`ifdef PEAK_THRESHOLD_EN
        check("rst_peak_valid", 64'(peak_valid), 0);
`endif
        @(negedge Clk);
        Reset = 1'b0;

        // Single tone at bin 37.
        clear_mem();
        mem_re[37] = 100;
        run_frame();
        check("tone_bin", 64'(peak_bin), 37);
        check("tone_mag", peak_mag, 10000);

        // Tie between bins 20 and 300 keeps the lower one.
        for (int i = 0; i < N; i++) begin
            mem_re[i] = 1;
            mem_im[i] = 1;
        end
        mem_re[20] = -3000; mem_im[20] = 4000;
        mem_re[300] = -3000; mem_im[300] = 4000;
        run_frame();
        check("tie_bin", 64'(peak_bin), 20);
        check("tie_mag", peak_mag, 25000000);

        // DC and upper-half bins must not be read.
        clear_mem();
        mem_re[0] = 32767; mem_im[0] = 32767;
        mem_re[600] = 32767;
        mem_re[5] = 10;
        run_frame();
        check("dc_skip_bin", 64'(peak_bin), 5);
        check("dc_skip_mag", peak_mag, 100);

        // Largest legal magnitude at the last bin.
        clear_mem();
        mem_re[511] = int'(32'h8000_0000);
        mem_im[511] = int'(32'h8000_0000);
        run_frame();
        check("maxmag_bin", 64'(peak_bin), 511);
        check("maxmag_mag", peak_mag, 64'h8000_0000_0000_0000);

        // All-zero frame.
        clear_mem();
        run_frame();
        check("zero_bin", 64'(peak_bin), 0);
        check("zero_mag", peak_mag, 0);

        // Reset mid-scan (with Start asserted) discards the partial scan.
        clear_mem();
        mem_re[10] = 30000;
        do_start();
        repeat (199) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_busy", 64'(Busy), 0);
        check("midrst_done", 64'(Done), 0);
        check("midrst_rd_en", 64'(rd_en), 0);
        check("midrst_rd_addr", 64'(rd_addr), 0);
        check("midrst_peak_bin", 64'(peak_bin), 0);
        check("midrst_peak_mag", peak_mag, 0);
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        check("midrst_stays_idle", 64'(Busy), 0);
        mem_re[10] = 0;
        mem_re[400] = 9;
        run_frame();
        check("restart_bin", 64'(peak_bin), 400);
        check("restart_mag", peak_mag, 81);

        // Randomized frames: full-range values, then small values to force ties.
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f < 3) begin
                    mem_re[i] = int'($urandom);
                    mem_im[i] = int'($urandom);
                end else begin
                    mem_re[i] = int'($urandom_range(0, 6)) - 3;
                    mem_im[i] = int'($urandom_range(0, 6)) - 3;
                end
            end
            run_frame();
        end

`ifdef PEAK_THRESHOLD_EN
        // Threshold gate, sampled at Start.
        clear_mem();
        mem_re[37] = 100;
        cur_thr = 64'd20000;
        run_frame();
        check("thr_high_valid", 64'(peak_valid), 0);
        check("thr_high_bin", 64'(peak_bin), 0);
        check("thr_high_mag", peak_mag, 0);
        cur_thr = 64'd10000;
        run_frame();
        check("thr_eq_valid", 64'(peak_valid), 1);
        check("thr_eq_bin", 64'(peak_bin), 37);
        check("thr_eq_mag", peak_mag, 10000);
`endif

        repeat (3) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
